// File: rtl/pwm_ctrl_pkg.sv
// Shared constants and types for the pwm duty command stage.
package pwm_ctrl_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] ADDR_DUTY_L = 3'd0;
    localparam logic [2:0] ADDR_DUTY_H = 3'd1;
    localparam logic [2:0] ADDR_FREQ_L = 3'd2;
    localparam logic [2:0] ADDR_FREQ_H = 3'd3;
    localparam logic [2:0] ADDR_CTRL   = 3'd4;
    localparam logic [2:0] ADDR_STEP   = 3'd5;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        RUN      = 2'd1,
        FAILSAFE = 2'd2
    } ctrlState_t;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/pwm_slew_step.sv
// One slew step: move current toward target by at most step.
// A zero step jumps straight to the target.
module pwm_slew_step
    import pwm_ctrl_pkg::*;
(
    input  word_t      current,
    input  word_t      target,
    input  logic [7:0] step,
    output word_t      nextDuty
);

    logic          up;
    word_t         hi;
    word_t         lo;
    logic [DATA_W:0] diff;
    logic [DATA_W:0] stepExt;

    always_comb begin
        up       = (target >= current);
        hi       = up ? target : current;
        lo       = up ? current : target;
        diff     = {1'b0, hi} - {1'b0, lo};
        stepExt  = {{(DATA_W - 7){1'b0}}, step};
        nextDuty = target;
        if (step != 8'd0 && diff > stepExt) begin
            nextDuty = up ? current + {8'd0, step}
                          : current - {8'd0, step};
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Host-facing duty/period command stage with slew limiting and
// a watchdog that forces a failsafe duty when commits stop.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int          TICK_DIV      = 1000,
    parameter int          TIMEOUT_TICKS = 50,
    parameter logic [15:0] FAILSAFE_DUTY = 16'h0000,
    parameter logic [15:0] FREQ_RESET    = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] pwmDutyl,
    output logic [7:0] pwmDutyh,
    output logic [7:0] pwmFreql,
    output logic [7:0] pwmFreqh,
    output logic       pwm_on,
    output logic       timeout
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int WD_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_TICKS);

    ctrlState_t       state;
    word_t            duty;
    word_t            target;
    word_t            period;
    logic [7:0]       dutyLo;
    logic [7:0]       freqLo;
    logic [7:0]       step;
    logic [CNT_W-1:0] tickCnt;
    logic [WD_W-1:0]  wdog;

    logic       wrDutyLo;
    logic       commit;
    logic       wrFreqLo;
    logic       wrFreqHi;
    logic       wrStep;
    logic       enWr;
    logic       disWr;
    logic       tick;
    logic       expire;
    logic [WD_W-1:0] wdNext;
    word_t      newTarget;
    word_t      slewTarget;
    word_t      slewNext;

    always_comb begin
        wrDutyLo = 1'b0;
        commit   = 1'b0;
        wrFreqLo = 1'b0;
        wrFreqHi = 1'b0;
        wrStep   = 1'b0;
        enWr     = 1'b0;
        disWr    = 1'b0;
        if (wr_en) begin
            unique case (1'b1)
                (wr_addr == ADDR_DUTY_L): wrDutyLo = 1'b1;
                (wr_addr == ADDR_DUTY_H): commit   = 1'b1;
                (wr_addr == ADDR_FREQ_L): wrFreqLo = 1'b1;
                (wr_addr == ADDR_FREQ_H): wrFreqHi = 1'b1;
                (wr_addr == ADDR_STEP):   wrStep   = 1'b1;
                (wr_addr == ADDR_CTRL): begin
                    enWr  = wr_data[0];
                    disWr = ~wr_data[0];
                end
                default: ;
            endcase
        end
    end

    assign newTarget  = {wr_data, dutyLo};
    assign tick       = (state != DISARMED) && (tickCnt == CNT_MAX);
    assign wdNext     = wdog + 1'b1;
    assign expire     = tick && (state == RUN) && (wdNext == WD_LIMIT);
    assign slewTarget = (state == FAILSAFE) ? FAILSAFE_DUTY : target;

    pwm_slew_step uSlew (
        .current  (duty),
        .target   (slewTarget),
        .step     (step),
        .nextDuty (slewNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DISARMED;
            duty    <= '0;
            target  <= '0;
            period  <= FREQ_RESET;
            dutyLo  <= '0;
            freqLo  <= '0;
            step    <= '0;
            tickCnt <= '0;
            wdog    <= '0;
            pwm_on  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (wrDutyLo) dutyLo <= wr_data;
            if (wrFreqLo) freqLo <= wr_data;
            if (wrFreqHi) period <= {wr_data, freqLo};
            if (wrStep)   step   <= wr_data;
            if (commit)   target <= newTarget;

            unique case (state)
                DISARMED: begin
                    duty    <= '0;
                    tickCnt <= '0;
                    wdog    <= '0;
                    timeout <= 1'b0;
                    if (enWr) begin
                        state  <= RUN;
                        pwm_on <= 1'b1;
                    end
                end
                RUN, FAILSAFE: begin
                    tickCnt <= tick ? '0 : tickCnt + 1'b1;
                    if (disWr) begin
                        state   <= DISARMED;
                        duty    <= '0;
                        tickCnt <= '0;
                        wdog    <= '0;
                        pwm_on  <= 1'b0;
                        timeout <= 1'b0;
                    end else if (commit) begin
                        // a tick coinciding with a commit still slews
                        // toward the target registered before it
                        state   <= RUN;
                        timeout <= 1'b0;
                        wdog    <= '0;
                        if (step == 8'd0)
                            duty <= newTarget;
                        else if (tick)
                            duty <= slewNext;
                    end else if (expire) begin
                        state   <= FAILSAFE;
                        timeout <= 1'b1;
                        duty    <= (step == 8'd0) ? FAILSAFE_DUTY
                                                  : slewNext;
                    end else begin
                        if (tick && state == RUN)
                            wdog <= wdNext;
                        if (tick || step == 8'd0)
                            duty <= slewNext;
                    end
                end
                default: begin
                    state  <= DISARMED;
                    pwm_on <= 1'b0;
                end
            endcase
        end
    end

    assign pwmDutyl = duty[7:0];
    assign pwmDutyh = duty[15:8];
    assign pwmFreql = period[7:0];
    assign pwmFreqh = period[15:8];

endmodule
